eth_phy_10g_rx_descrambler: RTL and testbench

// - Downstream of eth_phy_10g_rx_aligner in the 10GBASE-R RX PHY path.
// - Takes aligned 64b/66b blocks (sync header + payload) and descrambles the payload

---
 rtl/eth_phy_10g_rx_descrambler_pkg.sv | 20 ++
 rtl/eth_phy_10g_ber_mon.sv | 77 +++++++
 rtl/eth_phy_10g_rx_descrambler.sv | 105 ++++++++++
 tb/tb_eth_phy_10g_rx_descrambler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_10g_rx_descrambler_pkg.sv
// Shared 10GBASE-R PCS constants used by the RX descrambler and the TX scrambler.
//   SYNC_DATA / SYNC_CTRL : the two legal 64b/66b sync headers
//   SCR_POLY_TAP_A/B      : exponents of the scrambler polynomial x^58 + x^39 + 1
//   is_bad_hdr()          : true for the illegal sync headers 00 and 11
package eth_phy_10g_rx_descrambler_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int unsigned SCR_POLY_TAP_A = 58;
  localparam int unsigned SCR_POLY_TAP_B = 39;

  // Scrambler state holds the last TAP_A received scrambled bits.
  localparam int unsigned SCR_STATE_W = SCR_POLY_TAP_A;

  function automatic logic is_bad_hdr(input logic [1:0] hdr);
    return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
  endfunction

endpackage

// File: rtl/eth_phy_10g_ber_mon.sv
// High bit-error-rate monitor for the 10GBASE-R RX path.
// Counts bad sync headers over a window of aligned cycles; raises o_hi_ber as soon as the
// count reaches BER_THRESH and clears it at the end of a window that stayed below threshold.
//   clk, rst      : block clock, async active-high reset
//   i_aligned     : aligner lock; 0 restarts the monitor and clears all state
//   i_bad_hdr     : the block accepted this cycle has an illegal sync header
//   o_hi_ber      : high bit-error-rate flag
//   o_err_count   : bad headers in the current window, saturating at 255
module eth_phy_10g_ber_mon #(
  parameter int unsigned BER_WINDOW = 19531,
  parameter int unsigned BER_THRESH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_aligned,
  input  logic       i_bad_hdr,
  output logic       o_hi_ber,
  output logic [7:0] o_err_count
);

  localparam int unsigned    WinW    = $clog2(BER_WINDOW);
  localparam logic [WinW-1:0] WinLast = WinW'(BER_WINDOW - 1);
  localparam logic [7:0]     Thresh  = 8'(BER_THRESH);

  logic [WinW-1:0] win_q, win_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      cnt_inc;
  logic            hi_ber_q, hi_ber_d;

  always_comb begin
    cnt_inc  = cnt_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    hi_ber_d = hi_ber_q;

    if (i_bad_hdr && (cnt_q != 8'hFF)) begin
      cnt_inc = cnt_q + 8'd1;
    end

    if (!i_aligned) begin
      win_d    = '0;
      cnt_d    = '0;
      hi_ber_d = 1'b0;
    end else begin
      if (cnt_inc >= Thresh) begin
        hi_ber_d = 1'b1;
      end
      // The last window cycle's own header is included before deciding whether to clear.
      if (win_q == WinLast) begin
        win_d = '0;
        cnt_d = '0;
        if (cnt_inc < Thresh) begin
          hi_ber_d = 1'b0;
        end
      end else begin
        win_d = win_q + WinW'(1);
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q    <= '0;
      cnt_q    <= '0;
      hi_ber_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      hi_ber_q <= hi_ber_d;
    end
  end

  assign o_hi_ber    = hi_ber_q;
  assign o_err_count = cnt_q;

endmodule

// File: rtl/eth_phy_10g_rx_descrambler.sv
// 10GBASE-R RX descrambler with sync-header check and high-BER monitor.
// Descrambles aligned 64b/66b payloads with the self-synchronising polynomial
// x^58 + x^39 + 1; the sync header passes through untouched. One cycle of latency.
//   clk, rst          : block clock, async active-high reset
//   i_serdes_rx_hdr   : aligned sync header
//   i_serdes_rx_data  : aligned scrambled payload, bit 0 received first
//   i_aligned         : aligner lock, input block valid this cycle
//   o_rx_hdr/o_rx_data: registered header and descrambled payload (held while unlocked)
//   o_rx_valid        : outputs hold a valid block
//   o_hdr_err         : the block on the outputs had an illegal header
//   o_hi_ber          : high bit-error-rate indication
//   o_err_count       : bad headers in the current monitor window
module eth_phy_10g_rx_descrambler
  import eth_phy_10g_rx_descrambler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64, // only 64 supported
  parameter int unsigned HDR_WIDTH  = 2,  // only 2 supported
  parameter int unsigned BER_WINDOW = 19531,
  parameter int unsigned BER_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HDR_WIDTH-1:0]  i_serdes_rx_hdr,
  input  logic [DATA_WIDTH-1:0] i_serdes_rx_data,
  input  logic                  i_aligned,
  output logic [HDR_WIDTH-1:0]  o_rx_hdr,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_hdr_err,
  output logic                  o_hi_ber,
  output logic [7:0]            o_err_count
);

  localparam int unsigned TapGap = SCR_POLY_TAP_A - SCR_POLY_TAP_B;

  logic [SCR_STATE_W-1:0]            scr_q, scr_d;
  logic [DATA_WIDTH+SCR_STATE_W-1:0] ext;
  logic [DATA_WIDTH-1:0]             descr;
  logic [DATA_WIDTH-1:0]             data_q, data_d;
  logic [HDR_WIDTH-1:0]              hdr_q, hdr_d;
  logic                              valid_q, valid_d;
  logic                              hdr_err_q, hdr_err_d;
  logic                              bad_hdr;

  // ext[j] for j < 58 is the bit received 58-j bits before the current block's bit 0, so
  // each output bit taps the scrambled stream 58 and 39 bits back.
  always_comb begin
    ext   = {i_serdes_rx_data, scr_q};
    descr = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      descr[i] = ext[i+SCR_POLY_TAP_A] ^ ext[i+TapGap] ^ ext[i];
    end
  end

  assign bad_hdr = i_aligned && is_bad_hdr(i_serdes_rx_hdr);

  always_comb begin
    scr_d     = scr_q;
    data_d    = data_q;
    hdr_d     = hdr_q;
    valid_d   = 1'b0;
    hdr_err_d = 1'b0;
    if (i_aligned) begin
      scr_d     = i_serdes_rx_data[DATA_WIDTH-1 -: SCR_STATE_W];
      data_d    = descr;
      hdr_d     = i_serdes_rx_hdr;
      valid_d   = 1'b1;
      hdr_err_d = bad_hdr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_q     <= '0;
      data_q    <= '0;
      hdr_q     <= '0;
      valid_q   <= 1'b0;
      hdr_err_q <= 1'b0;
    end else begin
      scr_q     <= scr_d;
      data_q    <= data_d;
      hdr_q     <= hdr_d;
      valid_q   <= valid_d;
      hdr_err_q <= hdr_err_d;
    end
  end

  eth_phy_10g_ber_mon #(
    .BER_WINDOW (BER_WINDOW),
    .BER_THRESH (BER_THRESH)
  ) u_ber_mon (
    .clk         (clk),
    .rst         (rst),
    .i_aligned   (i_aligned),
    .i_bad_hdr   (bad_hdr),
    .o_hi_ber    (o_hi_ber),
    .o_err_count (o_err_count)
  );

  assign o_rx_hdr   = hdr_q;
  assign o_rx_data  = data_q;
  assign o_rx_valid = valid_q;
  assign o_hdr_err  = hdr_err_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_descrambler.sv
`timescale 1ns/1ps
module tb_eth_phy_10g_rx_descrambler;

  localparam int W  = 32;
  localparam int TH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  i_hdr = 2'b00;
  logic [63:0] i_data = '0;
  logic        i_al = 1'b0;
  logic [1:0]  o_rx_hdr;
  logic [63:0] o_rx_data;
  logic        o_rx_valid, o_hdr_err, o_hi_ber;
  logic [7:0]  o_err_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  eth_phy_10g_rx_descrambler #(
    .DATA_WIDTH (64),
    .HDR_WIDTH  (2),
    .BER_WINDOW (W),
    .BER_THRESH (TH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_serdes_rx_hdr  (i_hdr),
    .i_serdes_rx_data (i_data),
    .i_aligned        (i_al),
    .o_rx_hdr         (o_rx_hdr),
    .o_rx_data        (o_rx_data),
    .o_rx_valid       (o_rx_valid),
    .o_hdr_err        (o_hdr_err),
    .o_hi_ber         (o_hi_ber),
    .o_err_count      (o_err_count)
  );

  // ---------------- reference model (serial bit-stream view) ----------------
  bit          rx_hist[$];  // last 58 received scrambled bits, oldest first
  bit          tx_hist[$];  // last 58 transmitted scrambled bits, oldest first
  logic [63:0] m_data;
  logic [1:0]  m_hdr;
  bit          m_valid, m_hdr_err, m_hi;
  int          m_errs, m_win;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rx_hist.delete();
    for (int i = 0; i < 58; i++) rx_hist.push_back(1'b0);
    m_data = '0; m_hdr = '0; m_valid = 0; m_hdr_err = 0; m_hi = 0; m_errs = 0; m_win = 0;
  endtask

  task automatic tx_reset(input bit randomize_state);
    tx_hist.delete();
    for (int i = 0; i < 58; i++) tx_hist.push_back(randomize_state ? 1'($urandom) : 1'b0);
  endtask

  // Serial scrambler: s[n] = d[n] ^ s[n-39] ^ s[n-58].
  task automatic tx_scramble(input logic [63:0] p, output logic [63:0] s);
    for (int i = 0; i < 64; i++) begin
      s[i] = p[i] ^ tx_hist[19] ^ tx_hist[0];
      tx_hist.push_back(s[i]);
      void'(tx_hist.pop_front());
    end
  endtask

  task automatic model_step(input logic [1:0] hdr, input logic [63:0] data, input logic al);
    bit bad;
    if (al) begin
      for (int i = 0; i < 64; i++) begin
        m_data[i] = data[i] ^ rx_hist[19] ^ rx_hist[0];
        rx_hist.push_back(data[i]);
        void'(rx_hist.pop_front());
      end
      m_hdr     = hdr;
      m_valid   = 1;
      bad       = (hdr == 2'b00) || (hdr == 2'b11);
      m_hdr_err = bad;
      if (bad && m_errs < 255) m_errs++;
      if (m_errs >= TH) m_hi = 1;
      if (m_win == W - 1) begin
        if (m_errs < TH) m_hi = 0;
        m_errs = 0;
        m_win  = 0;
      end else begin
        m_win++;
      end
    end else begin
      m_valid = 0; m_hdr_err = 0; m_errs = 0; m_win = 0; m_hi = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"},   o_rx_valid,  m_valid);
    check_eq({tag, ".hdr_err"}, o_hdr_err,   m_hdr_err);
    check_eq({tag, ".hi_ber"},  o_hi_ber,    m_hi);
    check_eq({tag, ".err_cnt"}, o_err_count, 64'(m_errs));
    check_eq({tag, ".data"},    o_rx_data,   m_data);
    check_eq({tag, ".hdr"},     o_rx_hdr,    m_hdr);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input string tag, input logic [1:0] hdr, input logic [63:0] data,
                      input logic al);
    i_hdr = hdr; i_data = data; i_al = al;
    @(posedge clk);
    #1;
    model_step(hdr, data, al);
    check_all(tag);
    @(negedge clk);
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] plain, scr;
    bit flags[W];
    model_reset();
    tx_reset(0);

    // Reset held 500 ns.
    #500;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("unlocked", 2'b01, rnd64(), 1'b0);

    // Directed descramble from state 0.
    step("dir1", 2'b01, 64'h1, 1'b1);
    check_eq("dir1.const", o_rx_data, 64'h0400_0080_0000_0001);
    step("dir0", 2'b01, 64'h0, 1'b1);
    check_eq("dir0.const", o_rx_data, 64'h0);

    // Bad header.
    step("badhdr", 2'b11, 64'hFFFF_FFFF_7FFF_FFFF, 1'b1);
    check_eq("badhdr.err", o_hdr_err, 1'b1);
    check_eq("badhdr.cnt", o_err_count, 8'd1);
    check_eq("badhdr.hi", o_hi_ber, 1'b0);

    // Hi BER: restart monitor, 16 bad headers then 16 good in one window.
    step("relock", 2'b01, rnd64(), 1'b0);
    for (int i = 0; i < W; i++) begin
      step("win1", (i < 16) ? bad_hdr() : good_hdr(), rnd64(), 1'b1);
      if (i == 14) check_eq("hi.15th", o_hi_ber, 1'b0);
      if (i == 15) check_eq("hi.16th", o_hi_ber, 1'b1);
    end
    check_eq("hi.win1_end", o_hi_ber, 1'b1);
    for (int i = 0; i < W; i++) begin
      step("win2", good_hdr(), rnd64(), 1'b1);
      if (i == W - 2) check_eq("hi.win2_pre", o_hi_ber, 1'b1);
    end
    check_eq("hi.win2_end", o_hi_ber, 1'b0);
    // 15 bad headers at shuffled positions never raise the flag.
    for (int i = 0; i < W; i++) flags[i] = (i < 15);
    for (int i = W - 1; i > 0; i--) begin
      int j;
      bit t;
      j = $urandom_range(0, i);
      t = flags[i]; flags[i] = flags[j]; flags[j] = t;
    end
    for (int i = 0; i < W; i++) begin
      step("win3", flags[i] ? bad_hdr() : good_hdr(), rnd64(), 1'b1);
      check_eq("hi.win3_low", o_hi_ber, 1'b0);
    end

    // Lock loss mid-window with hi_ber set.
    for (int i = 0; i < 20; i++) step("ll_pre", (i < 16) ? bad_hdr() : good_hdr(), rnd64(), 1);
    check_eq("ll.hi_set", o_hi_ber, 1'b1);
    plain = o_rx_data;
    step("ll", 2'b00, rnd64(), 1'b0);
    check_eq("ll.valid", o_rx_valid, 1'b0);
    check_eq("ll.hi", o_hi_ber, 1'b0);
    check_eq("ll.held", o_rx_data, plain);
    for (int i = 0; i < 5; i++) step("ll_post", good_hdr(), rnd64(), 1'b1);

    // Asynchronous reset mid-stream clears without a clock edge.
    for (int i = 0; i < 3; i++) step("pre_rst", bad_hdr(), rnd64(), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check_eq("async_rst.data", o_rx_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Loopback, both scramblers start at 0: bit-exact from the first block.
    tx_reset(0);
    for (int i = 0; i < 50; i++) begin
      plain = rnd64();
      tx_scramble(plain, scr);
      step("loop0", good_hdr(), scr, 1'b1);
      check_eq("loop0.plain", o_rx_data, plain);
    end

    // Loopback with a random TX state: self-synchronises after one block.
    pulse_reset();
    tx_reset(1);
    for (int i = 0; i < 1000; i++) begin
      plain = rnd64();
      tx_scramble(plain, scr);
      step("loopr", ($urandom_range(0, 19) == 0) ? bad_hdr() : good_hdr(), scr, 1'b1);
      if (i >= 1) check_eq("loopr.plain", o_rx_data, plain);
    end

    // Random lock/header mix against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) == 0) ? bad_hdr() : good_hdr(), rnd64(),
           $urandom_range(0, 9) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
